// File: rtl/codec_init_sequencer_if.sv
// Purpose : I2C register-controller request/response bundle between the codec
//           init sequencer (master) and the ADAU1761 I2C controller (slave).
// Signals : i2c_start   - one-cycle transaction request
//           i2c_rnw     - 1 = read, 0 = write
//           i2c_address - 16-bit codec register address
//           i2c_wdata   - write data
//           i2c_rdata   - read data, valid when i2c_busy falls after a read
//           i2c_busy    - high while the controller is mid-transaction
`timescale 1ns/1ps
interface codec_init_sequencer_if;
  logic        i2c_start;
  logic        i2c_rnw;
  logic [15:0] i2c_address;
  logic [7:0]  i2c_wdata;
  logic [7:0]  i2c_rdata;
  logic        i2c_busy;

  modport master (
    output i2c_start, i2c_rnw, i2c_address, i2c_wdata,
    input  i2c_rdata, i2c_busy
  );

  modport slave (
    input  i2c_start, i2c_rnw, i2c_address, i2c_wdata,
    output i2c_rdata, i2c_busy
  );
endinterface

// File: rtl/codec_init_sequencer.sv
// Purpose : Drives the ADAU1761 I2C register controller after power-up. Waits
//           out the codec power-up time, then on go walks an external
//           synchronous command ROM issuing register writes, masked polls with
//           retry, and timed delays. Reports completion or a latched error.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           i_go           - start/restart request (level, used in IDLE/DONE/ERROR)
//           o_init_done    - sequence completed (held until next go or rst)
//           o_init_err     - sequence aborted  (held until next go or rst)
//           o_err_code     - 00 none, 01 busy timeout, 10 poll exhausted
//           o_err_entry    - ROM index of the failing entry
//           o_rom_addr     - command ROM read address
//           i_rom_data     - {op[33:32], addr[31:16], data[15:8], mask[7:0]}, 1-cycle latency
//           i2c            - request/response bundle to the I2C controller
`timescale 1ns/1ps
module codec_init_sequencer #(
  parameter int unsigned ROM_AW         = 6,
  parameter int unsigned POWERUP_CYCLES = 1_228_800,
  parameter int unsigned DELAY_TICK     = 12_288,
  parameter logic [7:0]  POLL_MAX       = 8'd255,
  parameter logic [15:0] BUSY_TIMEOUT   = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_go,
  output logic                  o_init_done,
  output logic                  o_init_err,
  output logic [1:0]            o_err_code,
  output logic [ROM_AW-1:0]     o_err_entry,
  output logic [ROM_AW-1:0]     o_rom_addr,
  input  logic [33:0]           i_rom_data,
  codec_init_sequencer_if.master i2c
);

  typedef enum logic [3:0] {
    S_PWRUP, S_IDLE, S_FETCH, S_DECODE, S_WAIT_HI, S_WAIT_LO,
    S_CHECK, S_RETRY, S_DELAY, S_NEXT, S_DONE, S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00, OP_POLL = 2'b01, OP_DELAY = 2'b10, OP_END = 2'b11
  } op_e;

  state_e              r_state, w_next;
  logic [33:0]         r_entry;
  logic                r_fetch_ph;   // second FETCH cycle: ROM output is valid
  logic [31:0]         r_cnt;        // power-up count and DELAY_TICK prescaler
  logic [15:0]         r_to_cnt;     // busy-edge timeout
  logic [15:0]         r_units;      // remaining delay units
  logic [7:0]          r_poll_cnt;
  logic [7:0]          r_rdata;
  logic [ROM_AW-1:0]   r_rom_addr;
  logic [ROM_AW-1:0]   r_err_entry;
  logic [1:0]          r_err_code;
  logic                r_done, r_err;
  logic                r_start, r_rnw;
  logic [15:0]         r_address;
  logic [7:0]          r_wdata;

  op_e                 w_op;
  logic                w_match;
  logic [7:0]          w_poll_inc;
  logic                w_enter;
  logic                w_go_start;

  assign w_op       = op_e'(r_entry[33:32]);
  assign w_match    = ((r_rdata ^ r_entry[15:8]) & r_entry[7:0]) == 8'd0;
  assign w_poll_inc = r_poll_cnt + 8'd1;
  assign w_enter    = (w_next != r_state);
  assign w_go_start = i_go && (r_state inside {S_IDLE, S_DONE, S_ERROR});

  assign o_init_done     = r_done;
  assign o_init_err      = r_err;
  assign o_err_code      = r_err_code;
  assign o_err_entry     = r_err_entry;
  assign o_rom_addr      = r_rom_addr;
  assign i2c.i2c_start   = r_start;
  assign i2c.i2c_rnw     = r_rnw;
  assign i2c.i2c_address = r_address;
  assign i2c.i2c_wdata   = r_wdata;

  // NOTE: state and every register below use non-blocking (<=) so all flops
  // update together at the edge; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_PWRUP;
    else     r_state <= w_next;
  end

  // NOTE: w_next is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_PWRUP:  if (r_cnt == POWERUP_CYCLES - 1) w_next = S_IDLE;
      S_IDLE, S_DONE, S_ERROR:
                if (i_go) w_next = S_FETCH;
      S_FETCH:  if (r_fetch_ph) w_next = S_DECODE;
      S_DECODE: begin
        unique case (w_op)
          // Holding off while busy guarantees start is never raised mid-transaction.
          OP_WRITE, OP_POLL: if (!i2c.i2c_busy) w_next = S_WAIT_HI;
          OP_DELAY:          w_next = S_DELAY;
          OP_END:            w_next = S_DONE;
        endcase
      end
      S_WAIT_HI: begin
        if (i2c.i2c_busy)                           w_next = S_WAIT_LO;
        else if (r_to_cnt == BUSY_TIMEOUT - 16'd1)  w_next = S_ERROR;
      end
      S_WAIT_LO: begin
        if (!i2c.i2c_busy)                          w_next = S_CHECK;
        else if (r_to_cnt == BUSY_TIMEOUT - 16'd1)  w_next = S_ERROR;
      end
      S_CHECK: begin
        if (w_op != OP_POLL || w_match) w_next = S_NEXT;
        else if (w_poll_inc == POLL_MAX) w_next = S_ERROR;
        else                             w_next = S_RETRY;
      end
      S_RETRY:  if (r_cnt == DELAY_TICK - 1) w_next = S_DECODE;
      S_DELAY:  if (r_units == 16'd0) w_next = S_NEXT;
      S_NEXT:   w_next = (&r_rom_addr) ? S_DONE : S_FETCH;
      default:  w_next = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry     <= '0;
      r_fetch_ph  <= 1'b0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_units     <= '0;
      r_poll_cnt  <= '0;
      r_rdata     <= '0;
      r_rom_addr  <= '0;
      r_err_entry <= '0;
      r_err_code  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_rnw       <= 1'b0;
      r_address   <= '0;
      r_wdata     <= '0;
    end else begin
      r_start    <= 1'b0;
      r_to_cnt   <= w_enter ? 16'd0 : r_to_cnt + 16'd1;
      // Prescaler restarts on every state entry and on each completed delay unit.
      if (w_enter || (r_state == S_DELAY && r_cnt == DELAY_TICK - 1)) r_cnt <= '0;
      else                                                             r_cnt <= r_cnt + 32'd1;

      r_fetch_ph <= (r_state == S_FETCH) && !r_fetch_ph;
      if (r_state == S_FETCH && r_fetch_ph) r_entry <= i_rom_data;

      if (w_go_start) begin
        r_rom_addr  <= '0;
        r_poll_cnt  <= '0;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_err_code  <= 2'b00;
        r_err_entry <= '0;
      end

      if (r_state == S_DECODE) begin
        if (w_next == S_WAIT_HI) begin
          r_start   <= 1'b1;
          r_rnw     <= (w_op == OP_POLL);
          r_address <= r_entry[31:16];
          r_wdata   <= r_entry[15:8];
        end
        if (w_op == OP_DELAY) r_units <= r_entry[15:0];
      end

      if (r_state == S_DELAY && r_cnt == DELAY_TICK - 1 && r_units != 16'd0)
        r_units <= r_units - 16'd1;

      if (r_state == S_WAIT_LO && !i2c.i2c_busy) r_rdata <= i2c.i2c_rdata;

      if (r_state == S_CHECK && w_op == OP_POLL && !w_match) r_poll_cnt <= w_poll_inc;

      if (r_state == S_NEXT && w_next == S_FETCH) begin
        r_rom_addr <= r_rom_addr + ROM_AW'(1);
        r_poll_cnt <= '0;
      end

      if (w_enter && w_next == S_DONE) r_done <= 1'b1;

      if (w_enter && w_next == S_ERROR) begin
        r_err       <= 1'b1;
        r_err_code  <= (r_state == S_CHECK) ? 2'b10 : 2'b01;
        r_err_entry <= r_rom_addr;
      end
    end
  end

endmodule

// File: tb/tb_codec_init_sequencer.sv
`timescale 1ns/1ps
module tb_codec_init_sequencer;

  localparam int ROM_AW         = 4;
  localparam int POWERUP_CYCLES = 50;
  localparam int DELAY_TICK     = 10;
  localparam logic [7:0]  POLL_MAX     = 8'd4;
  localparam logic [15:0] BUSY_TIMEOUT = 16'd40;
  localparam int BUSY_LEN       = 20;

  localparam logic [1:0] OP_WR = 2'b00, OP_PL = 2'b01, OP_DL = 2'b10, OP_EN = 2'b11;

  typedef struct {
    logic        rnw;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic              o_init_done, o_init_err;
  logic [1:0]        o_err_code;
  logic [ROM_AW-1:0] o_err_entry, o_rom_addr;
  logic [33:0]       rom_data;
  logic [33:0]       rom [16];

  codec_init_sequencer_if bus ();

  codec_init_sequencer #(
    .ROM_AW(ROM_AW), .POWERUP_CYCLES(POWERUP_CYCLES), .DELAY_TICK(DELAY_TICK),
    .POLL_MAX(POLL_MAX), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .i_go(go),
    .o_init_done(o_init_done), .o_init_err(o_init_err),
    .o_err_code(o_err_code), .o_err_entry(o_err_entry),
    .o_rom_addr(o_rom_addr), .i_rom_data(rom_data),
    .i2c(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  txn_t       exp_q[$];
  int         start_cycles[$];
  logic [7:0] rd_q[$];
  logic [7:0] rd_default;
  logic       stuck;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[o_rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [33:0] ent(input logic [1:0] op, input logic [15:0] a,
                                      input logic [7:0] d, input logic [7:0] m);
    return {op, a, d, m};
  endfunction

  function automatic void push_txn(input logic rnw, input logic [15:0] a, input logic [7:0] d);
    txn_t t;
    t.rnw = rnw; t.addr = a; t.wdata = d;
    exp_q.push_back(t);
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = ent(OP_EN, 16'h0, 8'h0, 8'h0);
  endtask

  // I2C controller model: busy rises the cycle start is seen and lasts BUSY_LEN cycles.
  initial begin
    int bcnt;
    bcnt = 0;
    bus.i2c_busy  = 1'b0;
    bus.i2c_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.i2c_busy = 1'b0;
        bcnt = 0;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) bus.i2c_busy = 1'b0;
      end else if (bus.i2c_start && !stuck) begin
        bus.i2c_busy = 1'b1;
        bcnt = BUSY_LEN;
        if (bus.i2c_rnw) bus.i2c_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : rd_default;
      end
    end
  end

  // Scoreboard monitor: every start pulse is matched against the next expected transaction.
  initial begin
    txn_t e;
    forever begin
      @(posedge clk); #1;
      if (bus.i2c_start) begin
        start_cycles.push_back(cyc);
        check("start while busy", bus.i2c_busy, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected start addr", bus.i2c_address, 16'hxxxx);
        end else begin
          e = exp_q.pop_front();
          check("txn rnw", bus.i2c_rnw, e.rnw);
          check("txn addr", bus.i2c_address, e.addr);
          if (!e.rnw) check("txn wdata", bus.i2c_wdata, e.wdata);
        end
      end
    end
  end

  task automatic pulse_go(output int go_cyc);
    @(negedge clk);
    start_cycles.delete();
    go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget, output int end_cyc);
    int n;
    n = 0;
    end_cyc = -1;
    while (n < budget && end_cyc < 0) begin
      @(posedge clk); #1;
      if (o_init_done || o_init_err) end_cyc = cyc;
      n++;
    end
    if (end_cyc < 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no done/err within %0d cycles", name, budget);
    end
  endtask

  task automatic check_end(input string name, input logic d, input logic e,
                           input logic [1:0] code, input logic [ROM_AW-1:0] idx);
    check({name, " done"}, o_init_done, d);
    check({name, " err"}, o_init_err, e);
    check({name, " code"}, o_err_code, code);
    if (e) check({name, " entry"}, o_err_entry, idx);
    check({name, " sb drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int gc, ec, gap, gap0, gap3;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc, ec, gap, gap0, gap3;
    rst = 1'b1; go = 1'b0; stuck = 1'b0; rd_default = 8'h00;
    clear_rom();
    repeat (3) @(negedge clk);

    // T1: reset state, go during power-up is ignored
    check("rst done", o_init_done, 1'b0);
    check("rst err", o_init_err, 1'b0);
    check("rst code", o_err_code, 2'b00);
    check("rst rom_addr", o_rom_addr, '0);
    check("rst start", bus.i2c_start, 1'b0);
    rst = 1'b0;
    rom[0] = ent(OP_WR, 16'h4099, 8'h99, 8'h00);
    pulse_go(gc);
    repeat (POWERUP_CYCLES + 20) @(negedge clk);
    check("t1 starts during powerup", start_cycles.size(), 0);
    check("t1 done", o_init_done, 1'b0);

    // T2: two writes then END
    clear_rom();
    rom[0] = ent(OP_WR, 16'h4000, 8'h0E, 8'h00);
    rom[1] = ent(OP_WR, 16'h4015, 8'h01, 8'h00);
    push_txn(1'b0, 16'h4000, 8'h0E);
    push_txn(1'b0, 16'h4015, 8'h01);
    pulse_go(gc);
    wait_end("t2", 500, ec);
    check_end("t2", 1'b1, 1'b0, 2'b00, '0);
    check("t2 start count", start_cycles.size(), 2);

    // T3: poll fails three times then matches; retries spaced by busy + DELAY_TICK
    clear_rom();
    rom[0] = ent(OP_PL, 16'h4002, 8'h02, 8'h02);
    rom[1] = ent(OP_WR, 16'h4003, 8'h55, 8'h00);
    rd_q = '{8'h00, 8'h00, 8'h00, 8'h02};
    for (int i = 0; i < 4; i++) push_txn(1'b1, 16'h4002, 8'h00);
    push_txn(1'b0, 16'h4003, 8'h55);
    pulse_go(gc);
    wait_end("t3", 1000, ec);
    check_end("t3", 1'b1, 1'b0, 2'b00, '0);
    check("t3 start count", start_cycles.size(), 5);
    for (int i = 1; i < 4 && i < start_cycles.size(); i++) begin
      gap = start_cycles[i] - start_cycles[i-1];
      check_range("t3 retry gap", gap, BUSY_LEN + DELAY_TICK + 1, BUSY_LEN + DELAY_TICK + 5);
    end

    // T4: poll never matches -> POLL_MAX reads, error code 10 at entry 1
    clear_rom();
    rom[0] = ent(OP_WR, 16'h4000, 8'h01, 8'h00);
    rom[1] = ent(OP_PL, 16'h40F0, 8'hAA, 8'hFF);
    rd_default = 8'h00;
    push_txn(1'b0, 16'h4000, 8'h01);
    for (int i = 0; i < 4; i++) push_txn(1'b1, 16'h40F0, 8'h00);
    pulse_go(gc);
    wait_end("t4", 1000, ec);
    check_end("t4", 1'b0, 1'b1, 2'b10, 4'd1);
    check("t4 start count", start_cycles.size(), 5);

    // T5: busy never rises -> timeout code 01; then go restarts at entry 0 without power-up wait
    clear_rom();
    rom[0] = ent(OP_WR, 16'h4010, 8'h11, 8'h00);
    stuck = 1'b1;
    push_txn(1'b0, 16'h4010, 8'h11);
    pulse_go(gc);
    wait_end("t5", 500, ec);
    check_end("t5", 1'b0, 1'b1, 2'b01, 4'd0);
    if (start_cycles.size() > 0)
      check_range("t5 timeout cycles", ec - start_cycles[0], BUSY_TIMEOUT, BUSY_TIMEOUT + 3);
    stuck = 1'b0;
    push_txn(1'b0, 16'h4010, 8'h11);
    pulse_go(gc);
    wait_end("t5 restart", 500, ec);
    check_end("t5 restart", 1'b1, 1'b0, 2'b00, '0);
    if (start_cycles.size() > 0)
      check_range("t5 restart latency", start_cycles[0] - gc, 1, 10);

    // T6a: DELAY of 3 units adds 3*DELAY_TICK relative to a zero delay
    gap0 = 0; gap3 = 0;
    for (int k = 0; k < 2; k++) begin
      clear_rom();
      rom[0] = ent(OP_WR, 16'h4000, 8'h01, 8'h00);
      rom[1] = ent(OP_DL, 16'h0000, 8'h00, (k == 0) ? 8'h00 : 8'h03);
      rom[2] = ent(OP_WR, 16'h4001, 8'h02, 8'h00);
      push_txn(1'b0, 16'h4000, 8'h01);
      push_txn(1'b0, 16'h4001, 8'h02);
      pulse_go(gc);
      wait_end("t6a", 500, ec);
      check_end("t6a", 1'b1, 1'b0, 2'b00, '0);
      if (start_cycles.size() == 2) begin
        if (k == 0) gap0 = start_cycles[1] - start_cycles[0];
        else        gap3 = start_cycles[1] - start_cycles[0];
      end
    end
    check_range("t6a delay length", gap3 - gap0, 3 * DELAY_TICK - 2, 3 * DELAY_TICK + 2);

    // T6b: ROM full of writes with no END -> done after the last entry
    for (int i = 0; i < 16; i++) begin
      rom[i] = ent(OP_WR, 16'h5000 + 16'(i), 8'(i * 3), 8'h00);
      push_txn(1'b0, 16'h5000 + 16'(i), 8'(i * 3));
    end
    pulse_go(gc);
    wait_end("t6b", 1500, ec);
    check_end("t6b", 1'b1, 1'b0, 2'b00, '0);
    check("t6b start count", start_cycles.size(), 16);
    check("t6b last rom_addr", o_rom_addr, 4'hF);

    // T6c: rst while waiting for busy to fall clears every output
    clear_rom();
    rom[0] = ent(OP_WR, 16'h4020, 8'h77, 8'h00);
    push_txn(1'b0, 16'h4020, 8'h77);
    pulse_go(gc);
    for (int n = 0; n < 50 && start_cycles.size() == 0; n++) @(negedge clk);
    check("t6c start seen", start_cycles.size(), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6c done", o_init_done, 1'b0);
    check("t6c err", o_init_err, 1'b0);
    check("t6c code", o_err_code, 2'b00);
    check("t6c entry", o_err_entry, '0);
    check("t6c rom_addr", o_rom_addr, '0);
    check("t6c start", bus.i2c_start, 1'b0);
    check("t6c rnw", bus.i2c_rnw, 1'b0);
    check("t6c address", bus.i2c_address, 16'h0000);
    check("t6c wdata", bus.i2c_wdata, 8'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6c sb drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
